// File: rtl/xbar_credit_arbiter.sv
// xbar_credit_arbiter: per-output round-robin arbiter with credit flow control for an NxN crossbar
module xbar_credit_arbiter #(
  parameter int NUM_NODES = 8,
  parameter int ID_W = 8,
  parameter int CREDITS = 4,
  parameter int SEL_W = $clog2(NUM_NODES),
  parameter int CNT_W = $clog2(CREDITS + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_NODES-1:0]       req_valid,
  input  logic [NUM_NODES*ID_W-1:0]  req_dest,
  input  logic [NUM_NODES-1:0]       credit_return,
  output logic [NUM_NODES-1:0]       grant,
  output logic [NUM_NODES-1:0]       out_valid,
  output logic [NUM_NODES*SEL_W-1:0] out_sel,
  output logic [NUM_NODES*CNT_W-1:0] credits,
  output logic                       err_bad_dest,
  output logic                       err_credit
);
  logic [SEL_W-1:0] rr_ptr [NUM_NODES];
  logic [SEL_W-1:0] win_src [NUM_NODES];
  logic [NUM_NODES-1:0] win, bad;
  int s;
  always_comb begin
    win = '0;
    bad = '0;
    grant = '0;
    s = 0;
    for (int o = 0; o < NUM_NODES; o++) win_src[o] = '0;
    for (int i = 0; i < NUM_NODES; i++)
      bad[i] = req_valid[i] && 32'(req_dest[i*ID_W +: ID_W]) >= NUM_NODES;
    // scan backwards so the requester closest to rr_ptr is the last one written
    for (int o = 0; o < NUM_NODES; o++)
      for (int k = NUM_NODES - 1; k >= 0; k--) begin
        s = (int'(rr_ptr[o]) + k) % NUM_NODES;
        if (credits[o*CNT_W +: CNT_W] != '0 && req_valid[s] &&
            32'(req_dest[s*ID_W +: ID_W]) == o) begin
          win[o] = 1'b1;
          win_src[o] = SEL_W'(s);
        end
      end
    if (!reset) begin
      grant = bad;
      for (int o = 0; o < NUM_NODES; o++)
        if (win[o]) grant[win_src[o]] = 1'b1;
    end
  end
  always_ff @(posedge clock)
    if (reset) begin
      for (int o = 0; o < NUM_NODES; o++) begin
        rr_ptr[o] <= '0;
        credits[o*CNT_W +: CNT_W] <= CNT_W'(CREDITS);
      end
      out_valid <= '0;
      out_sel <= '0;
      err_bad_dest <= 1'b0;
      err_credit <= 1'b0;
    end else begin
      out_valid <= win;
      if (|bad) err_bad_dest <= 1'b1;
      for (int o = 0; o < NUM_NODES; o++) begin
        if (win[o]) begin
          rr_ptr[o] <= win_src[o] == SEL_W'(NUM_NODES - 1) ? '0 : win_src[o] + SEL_W'(1);
          out_sel[o*SEL_W +: SEL_W] <= win_src[o];
        end
        if (credit_return[o] && !win[o]) begin
          if (credits[o*CNT_W +: CNT_W] == CNT_W'(CREDITS)) err_credit <= 1'b1;
          else credits[o*CNT_W +: CNT_W] <= credits[o*CNT_W +: CNT_W] + CNT_W'(1);
        end else if (!credit_return[o] && win[o]) begin
          credits[o*CNT_W +: CNT_W] <= credits[o*CNT_W +: CNT_W] - CNT_W'(1);
        end
      end
    end
endmodule

// File: doc/xbar_credit_arbiter.md
Name: xbar_credit_arbiter

Overview:
- Per-output round-robin arbiter with credit-based flow control for the NUM_NODES x NUM_NODES packet crossbar.
- Each input presents its FIFO head (valid + dest). The block picks at most one input per output per cycle and pops the winning FIFO through grant.
- It drives the registered crossbar mux select for each output and tracks downstream buffer credits, so no output is sent a packet it cannot hold.

Parameters:
- NUM_NODES, 8, number of crossbar inputs and outputs.
- ID_W, 8, width of the packet dest field.
- CREDITS, 4, downstream buffer depth per output; also the credit counter reset value.
- SEL_W, $clog2(NUM_NODES), width of the mux select.
- CNT_W, $clog2(CREDITS+1), width of the credit counter.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_NODES  input i FIFO is non-empty.
- req_dest  in  NUM_NODES*ID_W  dest of input i head packet.
- credit_return  in  NUM_NODES  output o downstream freed one slot this cycle.
- grant  out  NUM_NODES  combinational; pops input i FIFO this cycle.
- out_valid  out  NUM_NODES  registered; output o latched a packet last cycle.
- out_sel  out  NUM_NODES*SEL_W  registered; source index for output o.
- credits  out  NUM_NODES*CNT_W  current credit count per output.
- err_bad_dest  out  1  sticky; a head had dest >= NUM_NODES.
- err_credit  out  1  sticky; credit_return arrived while the counter was at CREDITS.

Behaviour:
- Reset (synchronous, active-high), values on the next clock edge:
  - rr_ptr[o] = 0.
  - credits[o] = CREDITS.
  - out_valid = 0.
  - out_sel = 0.
  - err_bad_dest = 0, err_credit = 0.
  - grant is 0 while reset is high, regardless of inputs.
- Request matrix: req[o][i] = req_valid[i] && req_dest[i] == o. Each input requests at most one output.
- Arbitration for output o, only when credits[o] != 0:
  - Winner is the first i with req[o][i], scanning i = rr_ptr[o], rr_ptr[o]+1, ... mod NUM_NODES.
  - grant[i] = 1 for the winner, in the same cycle (zero-latency pop).
- Pointer update: on a win by input w, rr_ptr[o] <= (w+1) mod NUM_NODES. Wrap from NUM_NODES-1 goes to 0. With no win, the pointer holds.
- Output registers, one cycle after the grant:
  - out_valid[o] <= win; out_sel[o] <= w.
  - out_sel holds its old value when there is no win.
  - This matches the crossbar output register, which captures the mux on the grant edge.
- Credit counter, next value credits[o] + credit_return[o] - win[o]:
  - Win and return in the same cycle: count unchanged. This is legal even at 0, because a grant requires a count above 0.
  - Return while at CREDITS: count saturates at CREDITS and err_credit <= 1.
  - A count of 0 blocks output o. Requesters wait with req_valid held and no grant.
- Bad destination (req_valid[i] && req_dest[i] >= NUM_NODES):
  - grant[i] = 1 unconditionally, so the packet is dropped and the head cannot deadlock.
  - err_bad_dest <= 1.
  - No output, pointer or credit state changes.
- Fairness: with persistent requesters and credits available, each requester of an output wins within NUM_NODES cycles.
- Independent outputs: different outputs arbitrate in parallel the same cycle. Up to NUM_NODES grants per cycle.
- Reset mid-operation:
  - All pointers and credits reinitialize.
  - Pending out_valid clears.
  - Sticky errors clear.
- req_dest is ignored when req_valid = 0.

Test Plan:
- Reset, then idle -> grant = 0, out_valid = 0, credits all 4, both err flags 0.
- Inputs 1, 3 and 6 hold requests to dest 2 for 6 cycles, credit_return[2] pulsed each cycle -> grant order 1, 3, 6, 1, 3, 6. out_sel[2] follows one cycle later. rr_ptr wraps correctly.
- Input 0 requests dest 5 for 6 cycles with no credit_return -> 4 grants, credits[5] reaches 0, then grants stop. A single credit_return[5] pulse gives exactly one more grant on the next cycle.
- Same cycle grant and credit_return on output 4 with credits[4] = 2 -> credits[4] stays 2.
- Inputs 0..7 each target a distinct output the same cycle -> all 8 grants asserted. The next cycle all out_valid = 1 with out_sel[o] equal to the matching source.
- Input 3 head dest = 9 -> grant[3] = 1, err_bad_dest = 1, no out_valid. credit_return[0] at credits[0] = 4 -> err_credit = 1, count stays 4.
